// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks (state encoding, default width).
// Latency: none, declarations only.
// Backpressure: not applicable.
package serial_arith_pkg;

  localparam int DEF_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/full_sub.sv
// One-bit full subtractor: d = i0 - i1 - bin, with borrow out.
// Latency: purely combinational.
// Backpressure: none.
module full_sub (
  input  logic i0,
  input  logic i1,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = i0 ^ i1 ^ bin;
  assign bout = (~i0 & i1) | (~(i0 ^ i1) & bin);

endmodule

// File: rtl/serial_sub.sv
// Bit-serial unsigned subtractor producing (a - b) mod 2^W, LSB first, one bit per clock.
// Latency: W cycles of busy after the accepting edge, then a one-cycle done pulse.
// Backpressure: start is only sampled in IDLE; requests in RUN/DONE are dropped, not queued.
module serial_sub
  import serial_arith_pkg::*;
#(
  parameter int W = DEF_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] diff,
  output logic         bout
);

  localparam int            CW   = $clog2(W);
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  state_t        state, state_nxt;
  logic [W-1:0]  sa, sb;
  logic [CW-1:0] cnt;
  logic          bin;
  logic          d, bo;

  // Single shared subtractor cell working on the current LSBs.
  full_sub u_fsub (
    .i0   (sa[0]),
    .i1   (sb[0]),
    .bin  (bin),
    .d    (d),
    .bout (bo)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; the unused encoding falls back to IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (cnt == LAST) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Status flags registered from the next state so they align with the state change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= (state_nxt == RUN);
      done <= (state_nxt == DONE);
    end
  end

  // Operand capture, bit-serial shifting and result assembly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sa   <= '0;
      sb   <= '0;
      cnt  <= '0;
      bin  <= 1'b0;
      diff <= '0;
      bout <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sa   <= a;
            sb   <= b;
            cnt  <= '0;
            bin  <= 1'b0;
            diff <= '0;
            bout <= 1'b0;
          end
        end
        RUN: begin
          sa   <= sa >> 1;
          sb   <= sb >> 1;
          diff <= {d, diff[W-1:1]};
          bin  <= bo;
          cnt  <= cnt + 1'b1;
          if (cnt == LAST) bout <= bo;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/serial_sub.md
# serial_sub

Bit-serial unsigned subtractor computing `a - b` one bit per clock, LSB first, using a 1-bit full-subtractor cell and a registered borrow. It is the inverse-arithmetic counterpart of the team's combinational full-adder datapath. It is the area-minimal subtract path for lab datapaths that already carry a clock. A start/busy/done handshake frames each operation.

## Interface
Parameters:
- `W`, default 8: operand and result width, ≥ 2.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  request; sampled only in IDLE.
- `a`  in  W  minuend, captured when start is accepted.
- `b`  in  W  subtrahend, captured when start is accepted.
- `busy`  out  1  high while in RUN.
- `done`  out  1  one-cycle pulse when the result is valid.
- `diff`  out  W  result `(a - b) mod 2^W`; holds until the next accepted start.
- `bout`  out  1  final borrow; 1 iff `a < b` unsigned; holds with `diff`.

## Operation
States and transitions:
- IDLE → RUN on `start=1`.
- RUN → DONE when `cnt == W-1` at an edge.
- DONE → IDLE unconditionally.

On accepting start (IDLE):
- Load shift regs `sa←a`, `sb←b`.
- Clear `bin`, `cnt`, and `diff`.

Each RUN edge:
- Full-subtract `d = sa[0]^sb[0]^bin`.
- Borrow `bo = (~sa[0]&sb[0]) | (~(sa[0]^sb[0])&bin)`.
- Shift `sa`, `sb` right; shift `d` into `diff[W-1]` (`diff` shifts right).
- `bin←bo`; `cnt←cnt+1`.

At the final RUN edge:
- `bout←bo`.
- `diff` then holds the full result, bit-aligned.

Other rules:
- `start` in RUN or DONE is ignored; no queuing.
- Reset values: state IDLE, `busy=0`, `done=0`, `diff=0`, `bout=0`, `cnt=0`, `bin=0`.
- Reset mid-RUN aborts immediately. No `done` is produced and outputs return to reset values.
- `a`/`b` changes after acceptance have no effect.

## Timing
- Edge E0 accepts start. Edges E1..EW process bits 0..W-1. At EW the state becomes DONE.
- `busy` is high from after E0 until after EW, i.e. W cycles.
- `done` is high for exactly the one cycle after EW. `diff`/`bout` are valid from that cycle and held afterwards.
- Earliest next accept is E(W+2), so throughput is one operation per W+2 cycles.
- `busy`, `done`, `diff`, `bout` are all registered; no combinational path from inputs to outputs.

## Structure
- Sub-module `full_sub (i0, i1, bin, d, bout)`: combinational 1-bit full subtractor, instanced once.
- Shared package `serial_arith_pkg` holds:
  - the state encoding constants (IDLE=2'd0, RUN=2'd1, DONE=2'd2);
  - the default width 8, for reuse by a future serial adder.
- `cnt` width is `$clog2(W)`.
- The unused state encoding 2'd3 returns to IDLE.

## Test plan
- W=8, a=100, b=37, start pulse → `busy` for 8 cycles, then `done` 1 cycle with diff=63, bout=0.
- a=5, b=9 → diff=252, bout=1. Also a=0, b=0 → diff=0, bout=0. Also a=255, b=255 → diff=0, bout=0.
- a=0, b=1 (full borrow ripple) → diff=255, bout=1.
- Pulse start again with a=1, b=1 at cycle 3 of RUN and during DONE → ignored; the original result is delivered; exactly one `done`.
- Assert `rst_n=0` at cycle 4 of RUN → `busy=0`, `diff=0`, no `done`. After release, start a=10, b=3 → diff=7 after the normal latency.
- Hold start high continuously with a=200, b=100 → `done` every 10 cycles, diff=100 each time.
